// File: rtl/issue_scoreboard.sv
// Register scoreboard gating issue from the data-select stage into EXE.
// Tracks one outstanding writer per architectural register and a countdown
// until that writer's result can be forwarded; stalls issue on RAW/WAW hazards.
module issue_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned LAT_W  = 2,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic              issue_rf_wen,
  input  logic [4:0]        issue_rd,
  input  logic [LAT_W-1:0]  issue_fw_lat,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy_mask,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned AW = 5;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_d;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             alloc;
  logic             stall_inc;

  // Hazard detection from registered state only; busy with cnt==0 is forwardable
  always_comb begin
    raw1        = (issue_rs1 != '0) && busy_mask[issue_rs1] && (cnt_q[issue_rs1] != '0);
    raw2        = (issue_rs2 != '0) && busy_mask[issue_rs2] && (cnt_q[issue_rs2] != '0);
    waw         = issue_rf_wen && (issue_rd != '0) && busy_mask[issue_rd];
    issue_ready = !flush && !raw1 && !raw2 && !waw;
    alloc       = issue_valid && issue_ready && issue_rf_wen && (issue_rd != '0);
    stall_inc   = issue_valid && !issue_ready && (stall_cycles != '1);
  end

  // Next scoreboard state: flush clears all, else allocate / retire / count down
  always_comb begin
    busy_d = busy_mask;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (flush) begin
      busy_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (alloc && (issue_rd == AW'(i))) begin
          busy_d[i] = 1'b1;
          cnt_d[i]  = issue_fw_lat;
        end else if (wb_valid && (wb_addr == AW'(i))) begin
          busy_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - LAT_W'(1);
        end
      end
    end
    // x0 is hardwired zero and never tracked
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  // State registers and saturating stall counter (not cleared by flush)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask    <= '0;
      stall_cycles <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      busy_mask <= busy_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (stall_inc) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random
// traffic compared against a per-register busy/countdown reference model.
module tb_issue_scoreboard;

  localparam int unsigned NREG   = 32;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic              issue_ready;
  logic [4:0]        issue_rs1;
  logic [4:0]        issue_rs2;
  logic              issue_rf_wen;
  logic [4:0]        issue_rd;
  logic [LAT_W-1:0]  issue_fw_lat;
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic              flush;
  logic [NREG-1:0]   busy_mask;
  logic [PERF_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit              m_busy [NREG];
  int              m_cnt  [NREG];
  longint unsigned m_stall;

  issue_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rf_wen(issue_rf_wen), .issue_rd(issue_rd), .issue_fw_lat(issue_fw_lat),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit r1, r2, w;
    r1 = (issue_rs1 != 0) && m_busy[issue_rs1] && (m_cnt[issue_rs1] != 0);
    r2 = (issue_rs2 != 0) && m_busy[issue_rs2] && (m_cnt[issue_rs2] != 0);
    w  = issue_rf_wen && (issue_rd != 0) && m_busy[issue_rd];
    return !flush && !r1 && !r2 && !w;
  endfunction

  function automatic logic [NREG-1:0] model_mask();
    logic [NREG-1:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = m_busy[r];
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 0;
      m_cnt[r]  = 0;
    end
    m_stall = 0;
  endtask

  // Advance the model by one clock edge using the inputs held this cycle
  task automatic model_update(input bit rdy);
    if (issue_valid && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        m_busy[r] = 0;
        m_cnt[r]  = 0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (wb_valid && wb_addr != 0) begin
        m_busy[wb_addr] = 0;
        m_cnt[wb_addr]  = 0;
      end
      if (issue_valid && rdy && issue_rf_wen && issue_rd != 0) begin
        m_busy[issue_rd] = 1;
        m_cnt[issue_rd]  = int'(issue_fw_lat);
      end
    end
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit wen,
                       input int rd, input int lat, input bit wbv, input int wba,
                       input bit fl);
    issue_valid  = v;
    issue_rs1    = 5'(rs1);
    issue_rs2    = 5'(rs2);
    issue_rf_wen = wen;
    issue_rd     = 5'(rd);
    issue_fw_lat = LAT_W'(lat);
    wb_valid     = wbv;
    wb_addr      = 5'(wba);
    flush        = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare against model, take one clock edge, update model, return at negedge
  task automatic cyc(input string tag);
    bit er;
    er = model_ready();
    check({tag, "_ready"}, 64'(issue_ready), 64'(er));
    check({tag, "_busy"}, 64'(busy_mask), 64'(model_mask()));
    check({tag, "_stall"}, 64'(stall_cycles), m_stall);
    @(posedge clk);
    model_update(er);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    idle();
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW on a latency-2 producer
    drive(1, 0, 0, 1, 5, 2, 0, 0, 0);
    check("raw_alloc_ready", 64'(issue_ready), 64'd1);
    cyc("raw_t0");
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    check("raw_t1_ready", 64'(issue_ready), 64'd0);
    cyc("raw_t1");
    check("raw_t2_ready", 64'(issue_ready), 64'd0);
    cyc("raw_t2");
    check("raw_t3_ready", 64'(issue_ready), 64'd1);
    check("raw_stall", 64'(stall_cycles), 64'd2);
    cyc("raw_t3");
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0);
    cyc("raw_wb");

    // Latency-0 producer is forwardable next cycle
    drive(1, 0, 0, 1, 7, 0, 0, 0, 0);
    cyc("fwd_t0");
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
    check("fwd_ready", 64'(issue_ready), 64'd1);
    check("fwd_busy7", 64'(busy_mask[7]), 64'd1);
    cyc("fwd_t1");
    idle();
    cyc("fwd_idle");
    check("fwd_busy7_hold", 64'(busy_mask[7]), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc("fwd_wb");
    check("fwd_busy7_clr", 64'(busy_mask[7]), 64'd0);

    // WAW blocks until writeback clears the register
    drive(1, 0, 0, 1, 3, 3, 0, 0, 0);
    cyc("waw_t0");
    drive(1, 0, 0, 1, 3, 1, 1, 3, 0);
    check("waw_blocked", 64'(issue_ready), 64'd0);
    cyc("waw_t1");
    drive(1, 0, 0, 1, 3, 1, 0, 0, 0);
    check("waw_after_wb", 64'(issue_ready), 64'd1);
    cyc("waw_t2");
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc("waw_wb");

    // x0 is never tracked and never stalls
    drive(1, 0, 0, 1, 0, 3, 0, 0, 0);
    check("x0_ready", 64'(issue_ready), 64'd1);
    cyc("x0_t0");
    check("x0_busy", 64'(busy_mask), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    check("x0_src_ready", 64'(issue_ready), 64'd1);
    cyc("x0_wb");
    check("x0_busy_after_wb", 64'(busy_mask), 64'd0);

    // Flush squashes in-flight writers and blocks issue
    drive(1, 0, 0, 1, 4, 3, 0, 0, 0);
    cyc("fl_a4");
    drive(1, 0, 0, 1, 9, 3, 0, 0, 0);
    cyc("fl_a9");
    drive(1, 0, 0, 1, 12, 1, 1, 4, 1);
    check("fl_ready", 64'(issue_ready), 64'd0);
    cyc("fl_t0");
    idle();
    check("fl_busy", 64'(busy_mask), 64'd0);
    cyc("fl_t1");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int span;
      span = ($urandom_range(0, 7) == 0) ? 31 : 7;
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, span), $urandom_range(0, span),
            $urandom_range(0, 1) == 1, $urandom_range(0, span),
            $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, span),
            $urandom_range(0, 31) == 0);
      cyc("rnd");
    end

    // Asynchronous reset mid-run with regs 8..11 busy
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("pre_rst_flush");
    for (int r = 8; r < 12; r++) begin
      drive(1, 0, 0, 1, r, 3, 0, 0, 0);
      cyc("pre_rst_alloc");
    end
    idle();
    check("pre_rst_busy", 64'(busy_mask), 64'h0000_0F00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", 64'(busy_mask), 64'd0);
    check("mid_rst_stall", 64'(stall_cycles), 64'd0);
    check("mid_rst_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8, 9, 1, 8, 1, 0, 0, 0);
    cyc("post_rst");
    idle();
    cyc("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
